ahb3lite_interconnect_arbiter: RTL and testbench



---
 rtl/ahb3lite_interconnect_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ahb3lite_interconnect_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb3lite_interconnect_arbiter
// Brief    : AHB3-Lite master arbiter with static priority, round-robin ties,
//            burst/lock aware switching and optional starvation aging
//            (enabled by AHB3LITE_INTERCONNECT_ARB_AGING_EN).
// Revision : 1.0 - initial release
// ============================================================================
module ahb3lite_interconnect_arbiter #(
    parameter int  MASTERS     = 3,
    parameter int  AGE_LIMIT   = 16,
    localparam int MASTER_BITS = (MASTERS > 2) ? $clog2(MASTERS) : 1
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [MASTERS-1:0]          mstHSEL,
    input  logic [MASTERS-1:0][2:0]     mstpriority,
    input  logic [MASTERS-1:0]          mstHMASTLOCK,
    input  logic [MASTERS-1:0]          can_switch,
    input  logic                        HREADY,
    output logic [MASTERS-1:0]          granted_master,
    output logic [MASTER_BITS-1:0]      granted_master_idx,
    output logic [MASTER_BITS-1:0]      granted_master_idx_dly,
    output logic [MASTERS-1:0]          starved,
    output logic [1:0]                  arb_state
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_OWN  = 2'd1;
    localparam logic [1:0] c_ST_LOCK = 2'd2;
    localparam logic [MASTER_BITS:0] c_MASTERS_W = (MASTER_BITS+1)'(MASTERS);

    logic [1:0]                 r_state_q, w_state_d;
    logic [MASTER_BITS-1:0]     r_idx_q, w_idx_d;
    logic [MASTER_BITS-1:0]     r_idx_dly_q;
    logic [MASTERS-1:0][3:0]    w_eff;
    logic [3:0]                 w_top;
    logic [MASTER_BITS-1:0]     w_cand;
    logic [MASTER_BITS:0]       w_pos;
    logic                       w_found;
    logic                       w_any_req;
    logic                       w_own_lock;
    logic                       w_own_cs;

    assign w_any_req  = |mstHSEL;
    assign w_own_lock = mstHMASTLOCK[r_idx_q];
    assign w_own_cs   = can_switch[r_idx_q];

    always_comb begin
        w_top = 4'd0;
        for (int i = 0; i < MASTERS; i++) begin
            w_eff[i] = {starved[i], mstpriority[i]};
            if (mstHSEL[i] && (w_eff[i] > w_top)) begin
                w_top = w_eff[i];
            end
        end
    end

    // The round-robin pointer is the current owner: it only moves on an
    // ownership change, so the search starts just past the owner and
    // visits the owner last (keeps the grant when it is the sole top).
    always_comb begin
        w_cand  = r_idx_q;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 1; i <= MASTERS; i++) begin
            w_pos = {1'b0, r_idx_q} + (MASTER_BITS+1)'(i);
            if (w_pos >= c_MASTERS_W) begin
                w_pos = w_pos - c_MASTERS_W;
            end
            if (!w_found && mstHSEL[w_pos[MASTER_BITS-1:0]] &&
                (w_eff[w_pos[MASTER_BITS-1:0]] == w_top)) begin
                w_found = 1'b1;
                w_cand  = w_pos[MASTER_BITS-1:0];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_d = c_ST_OWN;
                    w_idx_d   = w_cand;
                end
            end
            c_ST_OWN: begin
                if (w_own_lock) begin
                    w_state_d = c_ST_LOCK;
                end else if (!w_any_req) begin
                    w_state_d = c_ST_IDLE;
                end else if (w_own_cs) begin
                    w_idx_d = w_cand;
                end
            end
            c_ST_LOCK: begin
                if (!w_own_lock) begin
                    if (!w_any_req) begin
                        w_state_d = c_ST_IDLE;
                    end else begin
                        w_state_d = c_ST_OWN;
                        if (w_own_cs) begin
                            w_idx_d = w_cand;
                        end
                    end
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state_q   <= c_ST_IDLE;
            r_idx_q     <= '0;
            r_idx_dly_q <= '0;
        end else if (HREADY) begin
            r_state_q   <= w_state_d;
            r_idx_q     <= w_idx_d;
            r_idx_dly_q <= r_idx_q;
        end
    end

`ifdef AHB3LITE_INTERCONNECT_ARB_AGING_EN
    localparam logic [7:0] c_AGE_MAX = 8'(AGE_LIMIT);

    logic [MASTERS-1:0][7:0] r_age_q, w_age_d;

    // A waiting requester ages only while someone else owns the bus;
    // winning the grant or dropping the request resets its age.
    always_comb begin
        for (int n = 0; n < MASTERS; n++) begin
            w_age_d[n] = r_age_q[n];
            if (!mstHSEL[n] || (w_idx_d == MASTER_BITS'(n))) begin
                w_age_d[n] = 8'd0;
            end else if ((r_idx_q != MASTER_BITS'(n)) && (r_age_q[n] < c_AGE_MAX)) begin
                w_age_d[n] = r_age_q[n] + 8'd1;
            end
            starved[n] = (r_age_q[n] == c_AGE_MAX);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_age_q <= '0;
        end else if (HREADY) begin
            r_age_q <= w_age_d;
        end
    end
`else
    assign starved = '0;
`endif

    always_comb begin
        granted_master          = '0;
        granted_master[r_idx_q] = 1'b1;
    end

    assign granted_master_idx     = r_idx_q;
    assign granted_master_idx_dly = r_idx_dly_q;
    assign arb_state              = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_interconnect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb3lite_interconnect_arbiter
// Brief    : Scoreboard bench for ahb3lite_interconnect_arbiter (3 masters,
//            AGE_LIMIT 4); aging expectations follow
//            AHB3LITE_INTERCONNECT_ARB_AGING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb3lite_interconnect_arbiter;

    localparam int S_IDLE = 0;
    localparam int S_OWN  = 1;
    localparam int S_LOCK = 2;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic            HREADY;
    logic [2:0]      hsel, lock, cs;
    logic [2:0][2:0] prio;
    logic [2:0]      gm;
    logic [1:0]      gidx, gdly;
    logic [2:0]      stv;
    logic [1:0]      st;

    typedef struct {
        int         idx;
        int         st;
        int         dly;
        logic [2:0] stv;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    ahb3lite_interconnect_arbiter #(
        .MASTERS   (3),
        .AGE_LIMIT (4)
    ) dut (
        .HCLK                   (HCLK),
        .HRESET                 (HRESET),
        .mstHSEL                (hsel),
        .mstpriority            (prio),
        .mstHMASTLOCK           (lock),
        .can_switch             (cs),
        .HREADY                 (HREADY),
        .granted_master         (gm),
        .granted_master_idx     (gidx),
        .granted_master_idx_dly (gdly),
        .starved                (stv),
        .arb_state              (st)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1; HREADY = 1'b0; hsel = '0; lock = '0; cs = '0; prio = '0;
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; HREADY = 1'b0; hsel = 3'b111; lock = 3'b111; cs = 3'b111;
        prio = {3'd7, 3'd7, 3'd7};
        sb.push_back('{0, S_IDLE, 0, 3'b000});
        tick();
        e = sb.pop_front();
        n_tests++;
        if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
            n_fail++; $display("FAIL reset_grant: got idx=%0d onehot=%b, want idx=%0d", gidx, gm, e.idx);
        end
        n_tests++;
        if (st !== 2'(e.st)) begin n_fail++; $display("FAIL reset_state: got %0d, want %0d", st, e.st); end
        n_tests++;
        if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL reset_dly: got %0d, want %0d", gdly, e.dly); end
        n_tests++;
        if (stv !== e.stv) begin n_fail++; $display("FAIL reset_starved: got %b, want %b", stv, e.stv); end
        HRESET = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        prio[1] = 3'd5; prio[2] = 3'd2; hsel = 3'b110; cs = 3'b111; HREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1, S_OWN, (k == 0) ? 0 : 1, 3'b000});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
                n_fail++; $display("FAIL prio_grant step %0d: got idx=%0d onehot=%b, want idx=%0d", k, gidx, gm, e.idx);
            end
            n_tests++;
            if (st !== 2'(e.st)) begin n_fail++; $display("FAIL prio_state step %0d: got %0d, want %0d", k, st, e.st); end
            n_tests++;
            if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL prio_dly step %0d: got %0d, want %0d", k, gdly, e.dly); end
            n_tests++;
            if (stv !== e.stv) begin n_fail++; $display("FAIL prio_starved step %0d: got %b, want %b", k, stv, e.stv); end
        end
    endtask

    task automatic test_round_robin();
        int seq[4] = '{1, 2, 0, 1};
        int dly[4] = '{0, 1, 2, 0};
        do_reset();
        prio = {3'd3, 3'd3, 3'd3}; hsel = 3'b111; cs = 3'b111; HREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{seq[k], S_OWN, dly[k], 3'b000});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
                n_fail++; $display("FAIL rr_grant step %0d: got idx=%0d onehot=%b, want idx=%0d", k, gidx, gm, e.idx);
            end
            n_tests++;
            if (st !== 2'(e.st)) begin n_fail++; $display("FAIL rr_state step %0d: got %0d, want %0d", k, st, e.st); end
            n_tests++;
            if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL rr_dly step %0d: got %0d, want %0d", k, gdly, e.dly); end
            n_tests++;
            if (stv !== e.stv) begin n_fail++; $display("FAIL rr_starved step %0d: got %b, want %b", k, stv, e.stv); end
        end
    endtask

    // M0 locks, M2 (prio 7) waits ten slots, lock drop hands over to M2,
    // a non-owner lock is ignored, then all requests vanish and the grant parks.
    task automatic test_lock();
        logic [2:0] xs;
        do_reset();
        prio[2] = 3'd7; HREADY = 1'b1;
        for (int k = 0; k < 16; k++) begin
            hsel = (k < 2) ? 3'b001 : (k < 13) ? 3'b101 : (k == 13) ? 3'b111 : 3'b000;
            lock = (k < 12) ? 3'b001 : (k == 13) ? 3'b010 : 3'b000;
            cs   = (k == 13) ? 3'b000 : 3'b111;
`ifdef AHB3LITE_INTERCONNECT_ARB_AGING_EN
            xs = (k >= 5 && k <= 11) ? 3'b100 : 3'b000;
`else
            xs = 3'b000;
`endif
            sb.push_back('{(k < 12) ? 0 : 2,
                           (k == 0) ? S_OWN : (k < 12) ? S_LOCK : (k < 14) ? S_OWN : S_IDLE,
                           (k < 13) ? 0 : 2, xs});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
                n_fail++; $display("FAIL lock_grant step %0d: got idx=%0d onehot=%b, want idx=%0d", k, gidx, gm, e.idx);
            end
            n_tests++;
            if (st !== 2'(e.st)) begin n_fail++; $display("FAIL lock_state step %0d: got %0d, want %0d", k, st, e.st); end
            n_tests++;
            if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL lock_dly step %0d: got %0d, want %0d", k, gdly, e.dly); end
            n_tests++;
            if (stv !== e.stv) begin n_fail++; $display("FAIL lock_starved step %0d: got %b, want %b", k, stv, e.stv); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        prio[1] = 3'd5; prio[2] = 3'd2; cs = 3'b111;
        for (int k = 0; k < 8; k++) begin
            HREADY = (k >= 1 && k <= 5) ? 1'b0 : 1'b1;
            hsel   = (k == 0) ? 3'b010 : 3'b100;
            sb.push_back('{(k < 6) ? 1 : 2, S_OWN, (k < 6) ? 0 : (k == 6) ? 1 : 2, 3'b000});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
                n_fail++; $display("FAIL stall_grant step %0d: got idx=%0d onehot=%b, want idx=%0d", k, gidx, gm, e.idx);
            end
            n_tests++;
            if (st !== 2'(e.st)) begin n_fail++; $display("FAIL stall_state step %0d: got %0d, want %0d", k, st, e.st); end
            n_tests++;
            if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL stall_dly step %0d: got %0d, want %0d", k, gdly, e.dly); end
            n_tests++;
            if (stv !== e.stv) begin n_fail++; $display("FAIL stall_starved step %0d: got %b, want %b", k, stv, e.stv); end
        end
    endtask

    task automatic test_reset_mid_lock();
        int xi[4] = '{2, 2, 0, 2};
        int xs[4] = '{S_OWN, S_LOCK, S_IDLE, S_OWN};
        int xd[4] = '{0, 2, 0, 0};
        do_reset();
        prio[2] = 3'd1; hsel = 3'b100; lock = 3'b100; cs = 3'b000;
        for (int k = 0; k < 4; k++) begin
            HRESET = (k == 2);
            HREADY = (k == 2) ? 1'b0 : 1'b1;
            sb.push_back('{xi[k], xs[k], xd[k], 3'b000});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
                n_fail++; $display("FAIL rstlock_grant step %0d: got idx=%0d onehot=%b, want idx=%0d", k, gidx, gm, e.idx);
            end
            n_tests++;
            if (st !== 2'(e.st)) begin n_fail++; $display("FAIL rstlock_state step %0d: got %0d, want %0d", k, st, e.st); end
            n_tests++;
            if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL rstlock_dly step %0d: got %0d, want %0d", k, gdly, e.dly); end
            n_tests++;
            if (stv !== e.stv) begin n_fail++; $display("FAIL rstlock_starved step %0d: got %b, want %b", k, stv, e.stv); end
        end
        HRESET = 1'b0;
    endtask

    // M1 (prio 7) always wins on priority; with aging M0 starves after four
    // waiting slots and takes one slot before M1 returns.
    task automatic test_aging();
        int ei, ed;
        logic [2:0] es;
        do_reset();
        prio[1] = 3'd7; prio[0] = 3'd0; hsel = 3'b011; cs = 3'b111; HREADY = 1'b1;
        for (int k = 0; k < 7; k++) begin
`ifdef AHB3LITE_INTERCONNECT_ARB_AGING_EN
            ei = (k == 5) ? 0 : 1;
            ed = (k == 0 || k == 6) ? 0 : 1;
            es = (k == 4) ? 3'b001 : 3'b000;
`else
            ei = 1;
            ed = (k == 0) ? 0 : 1;
            es = 3'b000;
`endif
            sb.push_back('{ei, S_OWN, ed, es});
            tick();
            e = sb.pop_front();
            n_tests++;
            if (gidx !== 2'(e.idx) || gm !== 3'(1 << e.idx)) begin
                n_fail++; $display("FAIL aging_grant step %0d: got idx=%0d onehot=%b, want idx=%0d", k, gidx, gm, e.idx);
            end
            n_tests++;
            if (st !== 2'(e.st)) begin n_fail++; $display("FAIL aging_state step %0d: got %0d, want %0d", k, st, e.st); end
            n_tests++;
            if (gdly !== 2'(e.dly)) begin n_fail++; $display("FAIL aging_dly step %0d: got %0d, want %0d", k, gdly, e.dly); end
            n_tests++;
            if (stv !== e.stv) begin n_fail++; $display("FAIL aging_starved step %0d: got %b, want %b", k, stv, e.stv); end
        end
    endtask

    initial begin
        HRESET = 1'b1; HREADY = 1'b0; hsel = '0; lock = '0; cs = '0; prio = '0;
        test_reset();
        test_priority();
        test_round_robin();
        test_lock();
        test_stall();
        test_reset_mid_lock();
        test_aging();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
